// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and AES byte/word transforms
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Forward S-box; index 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of a block lives at bits [127-8i -: 8]; i = row + 4*column.
  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t r;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    end
    return r;
  endfunction

  // Row r rotates left by r columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t r;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[127-8*(4*col)   -: 8];
      a1 = s[127-8*(4*col+1) -: 8];
      a2 = s[127-8*(4*col+2) -: 8];
      a3 = s[127-8*(4*col+3) -: 8];
      r[127-8*(4*col)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[127-8*(4*col+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[127-8*(4*col+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[127-8*(4*col+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic aes_block_t add_round_key(input aes_block_t s, input aes_block_t rk);
    return s ^ rk;
  endfunction

  // One AES-128 key schedule step: four new words from the previous four.
  function automatic aes_block_t key_step(input aes_block_t rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = rk[127:96];
    w1  = rk[95:64];
    w2  = rk[63:32];
    w3  = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]} ^ {rcon, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// rtl/aes_round_unit.sv - one combinational AES round with its key schedule step
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_rk,
  output logic [7:0]   next_rcon
);

  aes_block_t sb;
  aes_block_t sr;
  aes_block_t mc;

  // The round key used by this round is the one expanded from the incoming rk.
  assign next_rk    = key_step(rk, rcon);
  assign next_rcon  = xtime(rcon);

  assign sb         = sub_bytes(state);
  assign sr         = shift_rows(sb);
  assign mc         = mix_columns(sr);

  // The final round skips MixColumns.
  assign next_state = add_round_key(last ? sr : mc, next_rk);

endmodule

// File: rtl/aes_iter_core.sv
// rtl/aes_iter_core.sv - iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] msg,
  output logic         busy,
  output logic         done,
  output logic [127:0] o
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_rounds
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  fsm_t       fsm;
  logic [3:0] round;
  aes_block_t state_q;
  aes_block_t rk_q;
  logic [7:0] rcon_q;

  aes_block_t st_c [0:R];
  aes_block_t rk_c [0:R];
  logic [7:0] rc_c [0:R];
  logic       final_step;

  assign st_c[0] = state_q;
  assign rk_c[0] = rk_q;
  assign rc_c[0] = rcon_q;

  // Unrolled chain: unit j performs round number round+j.
  for (genvar j = 0; j < R; j++) begin : g_round
    logic [3:0] rnd;
    assign rnd = round + 4'(j);

    aes_round_unit u_round (
      .state      (st_c[j]),
      .rk         (rk_c[j]),
      .rcon       (rc_c[j]),
      .last       (rnd == 4'(NUM_ROUNDS)),
      .next_state (st_c[j+1]),
      .next_rk    (rk_c[j+1]),
      .next_rcon  (rc_c[j+1])
    );
  end

  // R divides 10, so the last round always lands on the final unit of the chain.
  assign final_step = (round + 4'(R - 1)) == 4'(NUM_ROUNDS);

  // Control FSM plus round registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      o       <= '0;
      round   <= '0;
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= msg ^ key;
            rk_q    <= key;
            rcon_q  <= 8'h01;
            round   <= 4'd1;
            busy    <= 1'b1;
            fsm     <= RUN;
          end
        end
        RUN: begin
          state_q <= st_c[R];
          rk_q    <= rk_c[R];
          rcon_q  <= rc_c[R];
          if (final_step) begin
            o     <= st_c[R];
            done  <= 1'b1;
            busy  <= 1'b0;
            round <= '0;
            fsm   <= IDLE;
          end else begin
            round <= round + 4'(R);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative AES-128 encryption core: accepts a 128-bit key and plaintext block on a start pulse, runs the ten AES rounds over multiple clock cycles with on-the-fly key expansion, and presents the ciphertext with a one-cycle done pulse. It generalises the single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) into a sequential, handshaked core. `ROUNDS_PER_CYCLE` trades area for latency.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: AES rounds applied per clock.
  - Legal values: 1, 2, 5, 10.
  - Any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `start` input 1: request; sampled only when idle.
- `key` input 128: cipher key; byte 0 in bits [127:120].
- `msg` input 128: plaintext block, same byte order as `key`.
- `busy` output 1: high while rounds are in progress.
- `done` output 1: one-cycle pulse when `o` becomes valid.
- `o` output 128: ciphertext; held until the next accepted start or reset.

## Operation
- States:
  - IDLE: `busy`=0. On `start`=1, capture:
    - state ← `msg` ^ `key` (round-0 AddRoundKey)
    - rk ← `key`
    - rcon ← 8'h01
    - round ← 1
    - go to RUN.
  - RUN: each cycle applies `ROUNDS_PER_CYCLE` chained rounds r = round … round+R−1.
    - Rounds 1–9: SubBytes → ShiftRows → MixColumns → AddRoundKey(next rk).
    - Round 10 omits MixColumns.
    - Key step per round: rk' = FIPS-197 expansion of rk using the current rcon; rcon' = xtime(rcon), giving 01,02,04,08,10,20,40,80,1b,36.
    - round ← round+R.
    - On the cycle that completes round 10: o ← state result, `done` ← 1 next cycle, go to IDLE.
- `start` while RUN is ignored; inputs are not re-sampled.
- `start`=1 in the cycle `done`=1 is accepted, because the FSM is already IDLE.
- `key` and `msg` are only read in the capture cycle. They may change freely afterwards.
- Internal state, rk and rcon are not cleared on completion. Only `o`, `busy` and `done` are architecturally visible.

## Timing
- Reset values: `busy`=0, `done`=0, `o`=128'h0, FSM=IDLE, round=0.
- Reset during RUN aborts:
  - Next cycle is IDLE with all outputs at reset values.
  - No `done` is produced for the aborted block.
- `start` and `rst` high together: reset wins.
- Start accepted at edge of cycle t:
  - `busy`=1 in cycles t+1 … t+10/R.
  - `done`=1 and `o` valid in cycle t+10/R+1.
  - Latencies (start cycle to done cycle): R=1: 11; R=2: 6; R=5: 3; R=10: 2.
- `o` updates only on completion. Between completions it is stable.
- Maximum throughput: one block per 10/R+1 cycles. Back-to-back operation uses start=1 during the done cycle.
- Round counter width: 4 bits. It must never exceed 10, so there is no wrap.

## Structure
- Package `aes_pkg` holds:
  - `typedef logic [127:0] aes_block_t`
  - `NUM_ROUNDS = 10`
  - the FSM state enum (IDLE, RUN)
  - the xtime function
- Sub-module `aes_round_unit` is combinational; one instance per unrolled round, generated `ROUNDS_PER_CYCLE` times.
  - Inputs: state, rk, rcon, `last` flag.
  - Outputs: next state, next rk, next rcon.
  - It reuses the existing SubBytes, ShiftRows, MixColumns and AddRoundKey modules plus a single-step key expansion.
  - The `last` flag bypasses MixColumns.
- The top level holds only registers, FSM and round counter.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, msg 3243f6a8885a308d313198a2e0370734 → o=3925841d02dc09fbdc118597196a0b32. Check `done` at cycle t+11 with R=1.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff → o=69c4e0d86a7b0430d8cdb78070b4c55a. Repeat for R=2, 5, 10 with latencies 6, 3 and 2.
- All-zero key and msg → o=66e94bd4ef8a2c3b884cfa59ca342b2e. Then issue a second start during the done cycle with the App. B vector → both ciphertexts are correct with no idle gap.
- `start` pulsed every cycle during RUN, with key and msg changed after capture → only the first block is processed. A single `done` is produced and o matches the captured inputs.
- Assert `rst` in cycle t+5 of an R=1 operation:
  - From cycle t+6 on, `busy`=0, `done`=0 and `o`=0, and no done follows.
  - A fresh start then yields the App. C.1 result.
- `rst` and `start` asserted together → remains IDLE with `busy`=0; no operation starts.
